// File: rtl/rate_changer_mc.sv
// Lockstep multi-channel decimator / interpolator with run-time rate R = 2^rate_log2.
// Build option RATE_CHANGER_HOLD_EN: interpolator repeats the last sample instead of zero-stuffing.
module rate_changer_mc #(
    parameter int unsigned WIDTH         = 16,
    parameter int unsigned CHANNELS      = 2,
    parameter int unsigned MAX_RATE_LOG2 = 4,
    parameter bit          DnI           = 1'b1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [$clog2(MAX_RATE_LOG2+1)-1:0] rate_log2,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [CHANNELS*WIDTH-1:0]          in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [CHANNELS*WIDTH-1:0]          out_data,
    output logic [MAX_RATE_LOG2-1:0]           phase
);

    localparam int unsigned DW = CHANNELS * WIDTH;
    localparam int unsigned RW = $clog2(MAX_RATE_LOG2 + 1);
    localparam int unsigned PW = MAX_RATE_LOG2;

    logic [RW-1:0] rate_q;
    logic [RW-1:0] rate_cl_c;
    logic [RW-1:0] r_eff_c;
    logic [PW-1:0] last_phase_c;
    logic [PW-1:0] phase_inc_c;
    logic [PW-1:0] phase_d;
    logic          slot_free_c;
    logic          accept_c;
    logic          beat_c;
    logic          out_valid_d;
    logic [DW-1:0] out_data_d;
    logic [DW-1:0] fill_c;

    // Rate is only re-sampled at a group boundary; mid-group it is held in rate_q.
    always_comb begin
        rate_cl_c    = (32'(rate_log2) > MAX_RATE_LOG2) ? RW'(MAX_RATE_LOG2) : rate_log2;
        r_eff_c      = (phase == '0) ? rate_cl_c : rate_q;
        last_phase_c = PW'((32'd1 << r_eff_c) - 32'd1);
        phase_inc_c  = (phase == last_phase_c) ? '0 : phase + PW'(1);
    end

    always_comb begin
        slot_free_c = !out_valid || out_ready;
        if (DnI) begin
            in_ready = slot_free_c && !rst;
        end else begin
            in_ready = slot_free_c && (phase == '0) && !rst;
        end
        accept_c = in_valid && in_ready;
    end

`ifdef RATE_CHANGER_HOLD_EN
    logic [DW-1:0] hold_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else if (accept_c) begin
            hold_q <= in_data;
        end
    end

    assign fill_c = hold_q;
`else
    assign fill_c = '0;
`endif

    // Next output word, valid and phase for both modes.
    always_comb begin
        out_valid_d = out_valid;
        out_data_d  = out_data;
        phase_d     = phase;
        beat_c      = 1'b0;
        if (DnI) begin
            if (accept_c) begin
                beat_c = 1'b1;
                if (phase == '0) begin
                    out_valid_d = 1'b1;
                    out_data_d  = in_data;
                end else begin
                    out_valid_d = 1'b0;
                end
            end else if (slot_free_c) begin
                out_valid_d = 1'b0;
            end
        end else begin
            if (accept_c) begin
                beat_c      = 1'b1;
                out_valid_d = 1'b1;
                out_data_d  = in_data;
            end else if (slot_free_c && (phase != '0)) begin
                beat_c      = 1'b1;
                out_valid_d = 1'b1;
                out_data_d  = fill_c;
            end else if (slot_free_c) begin
                out_valid_d = 1'b0;
            end
        end
        if (beat_c) begin
            phase_d = phase_inc_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            phase     <= '0;
            rate_q    <= '0;
        end else begin
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            phase     <= phase_d;
            rate_q    <= r_eff_c;
        end
    end

endmodule

// File: tb/tb_rate_changer_mc.sv
// Self-checking bench for rate_changer_mc: one decimator and one interpolator instance
// checked against transaction-level group models under random stimulus.
module tb_rate_changer_mc;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned CHANNELS = 2;
    localparam int unsigned MAXL = 4;
    localparam int unsigned DW = CHANNELS * WIDTH;
    localparam int unsigned RW = $clog2(MAXL + 1);
    localparam int unsigned PW = MAXL;

    logic          clk;
    logic          rst;
    logic [RW-1:0] dec_rate, itp_rate;
    logic          dec_in_valid, dec_in_ready, dec_out_valid, dec_out_ready;
    logic          itp_in_valid, itp_in_ready, itp_out_valid, itp_out_ready;
    logic [DW-1:0] dec_in_data, dec_out_data, itp_in_data, itp_out_data;
    logic [PW-1:0] dec_phase, itp_phase;

    int n_checks = 0;
    int n_pass = 0;

    rate_changer_mc #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .MAX_RATE_LOG2(MAXL), .DnI(1'b1)) u_dec (
        .clk(clk), .rst(rst), .rate_log2(dec_rate),
        .in_valid(dec_in_valid), .in_ready(dec_in_ready), .in_data(dec_in_data),
        .out_valid(dec_out_valid), .out_ready(dec_out_ready), .out_data(dec_out_data),
        .phase(dec_phase)
    );

    rate_changer_mc #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .MAX_RATE_LOG2(MAXL), .DnI(1'b0)) u_itp (
        .clk(clk), .rst(rst), .rate_log2(itp_rate),
        .in_valid(itp_in_valid), .in_ready(itp_in_ready), .in_data(itp_in_data),
        .out_valid(itp_out_valid), .out_ready(itp_out_ready), .out_data(itp_out_data),
        .phase(itp_phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int group_len(input int r);
        return 1 << ((r > int'(MAXL)) ? int'(MAXL) : r);
    endfunction

    function automatic logic [DW-1:0] word(input int i);
        return {WIDTH'(i + 32'h8000), WIDTH'(i)};
    endfunction

    task automatic do_reset();
        dec_in_valid = 1'b0; itp_in_valid = 1'b0;
        dec_out_ready = 1'b0; itp_out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        dec_rate = '0; itp_rate = '0; dec_in_data = '0; itp_in_data = '0;
        dec_in_valid = 1'b1; itp_in_valid = 1'b1; dec_out_ready = 1'b1; itp_out_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        n_checks++; if ({dec_out_valid, itp_out_valid} !== 2'b00) $display("FAIL rst_valid got=%b exp=00", {dec_out_valid, itp_out_valid}); else n_pass++;
        n_checks++; if (dec_out_data !== '0) $display("FAIL rst_dec_data got=%h exp=0", dec_out_data); else n_pass++;
        n_checks++; if (itp_out_data !== '0) $display("FAIL rst_itp_data got=%h exp=0", itp_out_data); else n_pass++;
        n_checks++; if ({dec_phase, itp_phase} !== '0) $display("FAIL rst_phase got=%h/%h exp=0", dec_phase, itp_phase); else n_pass++;
        n_checks++; if ({dec_in_ready, itp_in_ready} !== 2'b00) $display("FAIL rst_in_ready got=%b exp=00", {dec_in_ready, itp_in_ready}); else n_pass++;
        dec_in_valid = 1'b0; itp_in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if ({dec_in_ready, itp_in_ready} !== 2'b11) $display("FAIL post_rst_in_ready got=%b exp=11", {dec_in_ready, itp_in_ready}); else n_pass++;
        @(posedge clk); #1;
    endtask

    // Decimator model: each group starts at an accepted input, takes its length from the
    // rate presented then, and forwards only its first sample.
    task automatic test_decimator(input int n, input int rate_mode, input int ready_pct, input int valid_pct);
        logic [DW-1:0] q[$];
        int  pos, grp_r;
        bit  drain, exp_rdy, acc, cons;
        do_reset();
        pos = 0; grp_r = 1;
        for (int cyc = 0; cyc < n + 24; cyc++) begin
            drain = (cyc >= n);
            dec_in_valid  = !drain && (int'($urandom_range(99)) < valid_pct);
            dec_in_data   = DW'($urandom);
            dec_out_ready = drain || (int'($urandom_range(99)) < ready_pct);
            dec_rate      = (rate_mode < 0) ? RW'($urandom_range(7)) : RW'(rate_mode);
            @(negedge clk);
            exp_rdy = (q.size() == 0) || dec_out_ready;
            n_checks++; if (dec_out_valid !== (q.size() != 0)) $display("FAIL dec_valid cyc=%0d got=%b exp=%b", cyc, dec_out_valid, q.size() != 0); else n_pass++;
            if (q.size() != 0) begin
                n_checks++; if (dec_out_data !== q[0]) $display("FAIL dec_data cyc=%0d got=%h exp=%h", cyc, dec_out_data, q[0]); else n_pass++;
            end
            n_checks++; if (dec_in_ready !== exp_rdy) $display("FAIL dec_in_ready cyc=%0d got=%b exp=%b", cyc, dec_in_ready, exp_rdy); else n_pass++;
            n_checks++; if (dec_phase !== PW'(pos)) $display("FAIL dec_phase cyc=%0d got=%0d exp=%0d", cyc, dec_phase, pos); else n_pass++;
            acc  = dec_in_valid && exp_rdy;
            cons = (q.size() != 0) && dec_out_ready;
            if (cons) void'(q.pop_front());
            if (acc) begin
                if (pos == 0) begin
                    grp_r = group_len(int'(dec_rate));
                    q.push_back(dec_in_data);
                end
                pos = (pos + 1) % grp_r;
            end
            @(posedge clk); #1;
        end
    endtask

    // Interpolator model: each accepted input expands into a group of R words
    // (sample then R-1 fillers); the output always shows the oldest unconsumed word.
    task automatic test_interpolator(input int n, input int rate_mode, input int ready_pct, input int valid_pct);
        logic [DW-1:0] q[$];
        logic [DW-1:0] fill;
        int  grp_r, exp_ph;
        bit  drain, exp_rdy, acc, cons;
        do_reset();
        grp_r = 1;
        for (int cyc = 0; cyc < n + 24; cyc++) begin
            drain = (cyc >= n);
            itp_in_valid  = !drain && (int'($urandom_range(99)) < valid_pct);
            itp_in_data   = DW'($urandom);
            itp_out_ready = drain || (int'($urandom_range(99)) < ready_pct);
            itp_rate      = (rate_mode < 0) ? RW'($urandom_range(7)) : RW'(rate_mode);
            @(negedge clk);
            exp_rdy = (q.size() == 0) || ((q.size() == 1) && itp_out_ready);
            exp_ph  = (q.size() == 0) ? 0 : (grp_r - q.size() + 1) % grp_r;
            n_checks++; if (itp_out_valid !== (q.size() != 0)) $display("FAIL itp_valid cyc=%0d got=%b exp=%b", cyc, itp_out_valid, q.size() != 0); else n_pass++;
            if (q.size() != 0) begin
                n_checks++; if (itp_out_data !== q[0]) $display("FAIL itp_data cyc=%0d got=%h exp=%h", cyc, itp_out_data, q[0]); else n_pass++;
            end
            n_checks++; if (itp_in_ready !== exp_rdy) $display("FAIL itp_in_ready cyc=%0d got=%b exp=%b", cyc, itp_in_ready, exp_rdy); else n_pass++;
            n_checks++; if (itp_phase !== PW'(exp_ph)) $display("FAIL itp_phase cyc=%0d got=%0d exp=%0d", cyc, itp_phase, exp_ph); else n_pass++;
            acc  = itp_in_valid && exp_rdy;
            cons = (q.size() != 0) && itp_out_ready;
            if (cons) void'(q.pop_front());
            if (acc) begin
                grp_r = group_len(int'(itp_rate));
`ifdef RATE_CHANGER_HOLD_EN
                fill = itp_in_data;
`else
                fill = '0;
`endif
                q.push_back(itp_in_data);
                for (int k = 1; k < grp_r; k++) q.push_back(fill);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] got[$];
        int k;
        do_reset();
        dec_rate = RW'(1); dec_in_valid = 1'b1; k = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            dec_out_ready = !(cyc >= 1 && cyc <= 3);
            dec_in_data   = word(k);
            @(negedge clk);
            if (cyc >= 1 && cyc <= 3) begin
                n_checks++; if (dec_out_valid !== 1'b1) $display("FAIL bp_valid cyc=%0d got=%b exp=1", cyc, dec_out_valid); else n_pass++;
                n_checks++; if (dec_out_data !== word(0)) $display("FAIL bp_data cyc=%0d got=%h exp=%h", cyc, dec_out_data, word(0)); else n_pass++;
                n_checks++; if (dec_in_ready !== 1'b0) $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", cyc, dec_in_ready); else n_pass++;
                n_checks++; if (dec_phase !== PW'(1)) $display("FAIL bp_phase cyc=%0d got=%0d exp=1", cyc, dec_phase); else n_pass++;
            end
            if (dec_out_valid && dec_out_ready) got.push_back(dec_out_data);
            if (dec_in_valid && dec_in_ready) k++;
            @(posedge clk); #1;
        end
        dec_in_valid = 1'b0;
        n_checks++; if (got.size() !== 8) $display("FAIL bp_count got=%0d exp=8", got.size()); else n_pass++;
        for (int i = 0; i < got.size(); i++) begin
            n_checks++; if (got[i] !== word(2 * i)) $display("FAIL bp_seq idx=%0d got=%h exp=%h", i, got[i], word(2 * i)); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_group();
        int budget;
        do_reset();
        itp_rate = RW'(3); itp_out_ready = 1'b1; itp_in_valid = 1'b1; itp_in_data = word(5);
        @(posedge clk); #1;
        itp_in_valid = 1'b0;
        budget = 0;
        @(negedge clk);
        while (itp_phase !== PW'(3) && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        n_checks++; if (itp_phase !== PW'(3)) $display("FAIL rmg_reach_phase3 got=%0d exp=3", itp_phase); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b1; itp_in_valid = 1'b1; itp_in_data = word(7);
        @(negedge clk);
        n_checks++; if (itp_in_ready !== 1'b0) $display("FAIL rmg_ready_in_rst got=%b exp=0", itp_in_ready); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0; itp_in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (itp_out_valid !== 1'b0) $display("FAIL rmg_valid got=%b exp=0", itp_out_valid); else n_pass++;
        n_checks++; if (itp_out_data !== '0) $display("FAIL rmg_data got=%h exp=0", itp_out_data); else n_pass++;
        n_checks++; if (itp_phase !== '0) $display("FAIL rmg_phase got=%0d exp=0", itp_phase); else n_pass++;
        n_checks++; if (itp_in_ready !== 1'b1) $display("FAIL rmg_in_ready got=%b exp=1", itp_in_ready); else n_pass++;
        @(posedge clk); #1;
        itp_in_valid = 1'b1; itp_in_data = word(9);
        @(posedge clk); #1;
        itp_in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (itp_out_data !== word(9)) $display("FAIL rmg_fresh_data got=%h exp=%h", itp_out_data, word(9)); else n_pass++;
        n_checks++; if (itp_phase !== PW'(1)) $display("FAIL rmg_fresh_phase got=%0d exp=1", itp_phase); else n_pass++;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_decimator(64, 2, 100, 100);
        test_interpolator(64, 3, 100, 100);
        test_backpressure();
        test_decimator(400, -1, 70, 80);
        test_decimator(200, 7, 80, 90);
        test_interpolator(400, -1, 60, 50);
        test_interpolator(200, 7, 100, 100);
        test_reset_mid_group();
        test_decimator(300, 0, 50, 70);
        test_interpolator(300, 0, 50, 70);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rate_changer_mc.md
Name: rate_changer_mc

Overview:
- Single-clock, multi-channel successor to the dual-clock decimator/interpolator stage of the CIC filter chain. Uses valid/ready strobes instead of a separate slow clock.
- Decimates (keeps the first of every R samples) or interpolates (zero-stuffs R-1 zeros after each sample) all channels in lockstep.
- R = 2^rate_log2 is selectable at run time, up to a parameterised maximum.
- Sits between the CIC integrator and comb sections.

Parameters:
- WIDTH, 16, bits per channel sample.
- CHANNELS, 2, number of lockstep channels. Channel c occupies bits [c*WIDTH +: WIDTH].
- MAX_RATE_LOG2, 4, maximum log2 rate, must be >= 1. Maximum R = 16.
- DnI, 1, mode: 1 = decimator, 0 = interpolator.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous active-high reset.
- rate_log2  in  $clog2(MAX_RATE_LOG2+1)  requested log2 rate; values > MAX_RATE_LOG2 clamp to MAX_RATE_LOG2.
- in_valid  in  1  input sample valid.
- in_ready  out  1  input sample accepted when in_valid && in_ready.
- in_data  in  CHANNELS*WIDTH  input samples, all channels.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_data  out  CHANNELS*WIDTH  output samples.
- phase  out  MAX_RATE_LOG2  current position within the rate group (0..R-1).

Behaviour:
- Reset (rst high at posedge): out_valid=0, out_data=0, phase=0, rate_q=0. While rst is high, in_ready=0. rst overrides any transfer in the same cycle; a partial group is discarded.
- Output register:
  - out_valid/out_data are registered.
  - Output may load when !out_valid || out_ready (call this "slot free").
  - If out_valid && !out_ready, out_data is held stable and out_valid stays 1.
- Effective rate: r_eff = (phase==0) ? clamp(rate_log2) : rate_q; rate_q <= r_eff every cycle. Rate is therefore sampled only at group start; a mid-group change takes effect at the next group. R = 1<<r_eff.
- Phase counter: increments by 1 per beat (defined per mode) and wraps R-1 -> 0. When R=1 it stays 0.
- Decimator (DnI=1):
  - in_ready = slot free.
  - On accept with phase==0: out_data<=in_data, out_valid<=1.
  - On accept with phase!=0: sample dropped; out_valid<=0 if the slot was being consumed.
  - Beat = accepted input.
  - Latency: 1 cycle from accepted phase-0 input to out_valid.
  - Throughput: 1 output per R accepted inputs.
- Interpolator (DnI=0):
  - in_ready = (phase==0) && slot free.
  - On accept: out_data<=in_data, out_valid<=1.
  - While phase!=0 and slot free: out_data<=0, out_valid<=1. Zeros are generated without waiting for input.
  - Beat = output loaded.
  - Latency 1 cycle. Sustained rate: 1 input per R output beats.
- Rate 1 (rate_log2=0): pass-through with 1-cycle latency in both modes.
- Simultaneous out_ready and new load: the old word is consumed and the new word is loaded in the same cycle; no bubble.
- No data is ever lost while out_valid && !out_ready. The upstream stalls via in_ready.

Optional Feature:
- Macro RATE_CHANGER_HOLD_EN.
- Defined: the interpolator emits zero-order hold; the phase!=0 beats repeat the last accepted in_data instead of 0. The decimator is unaffected.
- Undefined: zero-stuffing as above.
- The macro has no effect on ports or latency.

Test Plan:
- Decimator, CHANNELS=2, rate_log2=2, in_valid=1 and out_ready=1 continuously, in_data ch0 = 0..15 -> out_data ch0 = 0,4,8,12, each 1 cycle after its input; out_valid high 1 cycle in 4; phase cycles 0,1,2,3.
- Interpolator, rate_log2=3, inputs ch0=5 then 9, out_ready=1 -> out = 5,0,0,0,0,0,0,0,9,0...; in_ready high only at phase 0. With RATE_CHANGER_HOLD_EN -> eight 5s then eight 9s.
- Backpressure: decimator R=2, out_ready=0 for 3 cycles while out_valid=1 -> out_data stable, in_ready=0, phase frozen; on release, no sample is dropped or duplicated.
- Mid-group rate change: decimator with rate_log2 changed 1->2 at phase 1 -> the current group still ends after 2 inputs, the next group lasts 4. rate_log2=7 with MAX=4 -> behaves as R=16.
- Reset mid-group: interpolator at phase 3 of R=8, rst high 1 cycle -> next cycle out_valid=0, out_data=0, phase=0, in_ready=1; the next input starts a fresh group.
- Pass-through: rate_log2=0, both modes, random data with random out_ready -> out equals the accepted input stream in order, 1-cycle latency.
